// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer for a shared 32-bit AND/OR/XOR/NOR unit; done pulses 2 cycles after the sampling edge.
// One operation in flight; losing or late requesters just hold req until they see their grant.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [OPW-1:0] OP_AND = 2'b00;
  localparam logic [OPW-1:0] OP_OR  = 2'b01;
  localparam logic [OPW-1:0] OP_XOR = 2'b10;

  logic [1:0]       state;
  logic             prio;
  logic             owner;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  logic             win_vld;
  logic             win;

  function automatic logic [WIDTH-1:0] eval(input logic [OPW-1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  eval = a & b;
      OP_OR:   eval = a | b;
      OP_XOR:  eval = a ^ b;
      default: eval = ~(a | b);
    endcase
  endfunction

  // prio only breaks ties; a lone requester always wins
  always_comb begin
    win_vld = req0 | req1;
    if (req0 && req1) win = prio;
    else              win = req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner <= win;
            prio  <= ~win;
            op_q  <= win ? op1 : op0;
            a_q   <= win ? a1  : a0;
            b_q   <= win ? b1  : b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q <= eval(op_q, a_q, b_q);
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0  = (state == EXEC) && !owner;
  assign gnt1  = (state == EXEC) &&  owner;
  assign done0 = (state == DONE) && !owner;
  assign done1 = (state == DONE) &&  owner;
  assign busy  = (state != IDLE);
  assign res   = res_q;

endmodule
